// File: rtl/dfs_pkg.sv
// Shared types and constants for the DFS MMCM reprogramming controller.
package dfs_pkg;

  localparam int unsigned DRP_ADDR_W = 7;
  localparam int unsigned DRP_DATA_W = 16;
  localparam int unsigned DIV_W      = 7;

  localparam logic [DRP_ADDR_W-1:0] CLKOUT0_REG1 = 7'h08;
  localparam logic [DRP_ADDR_W-1:0] CLKOUT0_REG2 = 7'h09;

  typedef enum logic [3:0] {
    S_IDLE, S_RST, S_WR0, S_WAIT0, S_WR1, S_WAIT1, S_REL, S_LOCK, S_ACK
  } state_t;

  // CLKOUT0 divider register layouts
  typedef struct packed {
    logic [2:0] phase_mux;
    logic       rsvd;
    logic [5:0] high_time;
    logic [5:0] low_time;
  } clkout_reg1_t;

  typedef struct packed {
    logic [7:0] rsvd;
    logic       edge_bit;
    logic       no_count;
    logic [5:0] delay_time;
  } clkout_reg2_t;

endpackage

// File: rtl/dfs_drp_ctrl_if.sv
// Request/acknowledge, DRP and MMCM control bundle of the DFS controller.
interface dfs_drp_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 13
);
  logic                  req_en_i;
  logic [DATA_WIDTH-1:0] req_data_i;
  logic                  ack_o;
  logic                  err_o;
  logic                  busy_o;
  logic [DATA_WIDTH-1:0] cur_freq_o;
  logic [6:0]            drp_daddr_o;
  logic [15:0]           drp_di_o;
  logic                  drp_den_o;
  logic                  drp_dwe_o;
  logic                  drp_drdy_i;
  logic                  mmcm_rst_o;
  logic                  mmcm_locked_i;

  modport master (
    output req_en_i, req_data_i, drp_drdy_i, mmcm_locked_i,
    input  ack_o, err_o, busy_o, cur_freq_o, drp_daddr_o, drp_di_o,
           drp_den_o, drp_dwe_o, mmcm_rst_o
  );

  modport slave (
    input  req_en_i, req_data_i, drp_drdy_i, mmcm_locked_i,
    output ack_o, err_o, busy_o, cur_freq_o, drp_daddr_o, drp_di_o,
           drp_den_o, drp_dwe_o, mmcm_rst_o
  );
endinterface

// File: rtl/dfs_div_encode.sv
// Combinational CLKOUT0 divide value to DRP register pair encoder.
module dfs_div_encode
  import dfs_pkg::*;
(
  input  logic [DIV_W-1:0] div,
  output clkout_reg1_t     reg1,
  output clkout_reg2_t     reg2
);

  always_comb begin
    reg1 = '0;
    reg2 = '0;
    // Divide-by-one bypasses the counter; high/low are don't-care but set to 1
    if (div == DIV_W'(1)) begin
      reg1.high_time = 6'd1;
      reg1.low_time  = 6'd1;
      reg2.no_count  = 1'b1;
    end else begin
      reg1.high_time = 6'(div >> 1);
      reg1.low_time  = 6'(div - (div >> 1));
    end
    reg2.edge_bit = div[0];
  end

endmodule

// File: rtl/dfs_drp_ctrl.sv
// Maps a frequency request to an MMCM divide and reprograms CLKOUT0 over DRP.
// Optional DFS_WATCHDOG_EN: bounds each wait for drdy/lock and aborts with err.
module dfs_drp_ctrl
  import dfs_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 13,
  parameter int unsigned N_FREQ         = 6,
  parameter int unsigned FREQS [N_FREQ] = '{480, 440, 400, 360, 320, 280},
  parameter int unsigned DIVS  [N_FREQ] = '{16, 17, 19, 21, 24, 27},
  parameter int unsigned INIT_IDX       = 1,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input logic           clk,
  input logic           rst,
  dfs_drp_ctrl_if.slave bus
);

  localparam int unsigned IDX_W = (N_FREQ > 1) ? $clog2(N_FREQ) : 1;
  localparam logic [DATA_WIDTH-1:0] INIT_FREQ = DATA_WIDTH'(FREQS[INIT_IDX]);

  state_t                  state;
  logic [IDX_W-1:0]        tgt_idx;
  logic [1:0]              blank_cnt;
  logic                    ack, err, busy, mmcm_rst, den, dwe;
  logic [DATA_WIDTH-1:0]   cur_freq;
  logic [DRP_ADDR_W-1:0]   daddr;
  logic [DRP_DATA_W-1:0]   di;
  logic                    hit;
  logic [IDX_W-1:0]        hit_idx;
  clkout_reg1_t            reg1;
  clkout_reg2_t            reg2;
  logic                    wd_expired;
  logic                    abort;

  // Exact-match search of the operating point table
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int unsigned i = 0; i < N_FREQ; i++) begin
      if (!hit && bus.req_data_i == DATA_WIDTH'(FREQS[i])) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

  dfs_div_encode u_enc (
    .div  (DIV_W'(DIVS[tgt_idx])),
    .reg1 (reg1),
    .reg2 (reg2)
  );

`ifdef DFS_WATCHDOG_EN
  localparam int unsigned WD_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [WD_W-1:0] wd_cnt;

  // Counter is zero outside the wait states, so every wait entry reloads it
  always_ff @(posedge clk) begin
    if (rst || !(state inside {S_WAIT0, S_WAIT1, S_LOCK})) wd_cnt <= '0;
    else                                                   wd_cnt <= wd_cnt + WD_W'(1);
  end

  assign wd_expired = (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
`else
  assign wd_expired = 1'b0;
`endif

  assign abort = wd_expired &&
                 (((state == S_WAIT0 || state == S_WAIT1) && !bus.drp_drdy_i) ||
                  (state == S_LOCK && blank_cnt == 2'd2 && !bus.mmcm_locked_i));

  // Outputs are registered together with the state they belong to
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      tgt_idx   <= IDX_W'(INIT_IDX);
      blank_cnt <= '0;
      ack       <= 1'b0;
      err       <= 1'b0;
      busy      <= 1'b0;
      mmcm_rst  <= 1'b0;
      den       <= 1'b0;
      dwe       <= 1'b0;
      daddr     <= '0;
      di        <= '0;
      cur_freq  <= INIT_FREQ;
    end else begin
      ack   <= 1'b0;
      den   <= 1'b0;
      dwe   <= 1'b0;
      daddr <= '0;
      di    <= '0;
      unique case (state)
        S_IDLE: if (bus.req_en_i) begin
          if (!hit) begin
            err <= 1'b1;
            ack <= 1'b1;
          end else if (bus.req_data_i == cur_freq) begin
            ack <= 1'b1;
          end else begin
            tgt_idx  <= hit_idx;
            mmcm_rst <= 1'b1;
            busy     <= 1'b1;
            state    <= S_RST;
          end
        end
        S_RST: begin
          den   <= 1'b1;
          dwe   <= 1'b1;
          daddr <= CLKOUT0_REG1;
          di    <= reg1;
          state <= S_WR0;
        end
        S_WR0: state <= S_WAIT0;
        S_WAIT0: if (bus.drp_drdy_i) begin
          den   <= 1'b1;
          dwe   <= 1'b1;
          daddr <= CLKOUT0_REG2;
          di    <= reg2;
          state <= S_WR1;
        end
        S_WR1: state <= S_WAIT1;
        S_WAIT1: if (bus.drp_drdy_i) begin
          mmcm_rst  <= 1'b0;
          blank_cnt <= '0;
          state     <= S_REL;
        end
        S_REL: state <= S_LOCK;
        // Lock status is stale right after release, so skip two samples
        S_LOCK: begin
          if (blank_cnt != 2'd2) begin
            blank_cnt <= blank_cnt + 2'd1;
          end else if (bus.mmcm_locked_i) begin
            ack      <= 1'b1;
            cur_freq <= DATA_WIDTH'(FREQS[tgt_idx]);
            state    <= S_ACK;
          end
        end
        S_ACK: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
      if (abort) begin
        err      <= 1'b1;
        ack      <= 1'b1;
        mmcm_rst <= 1'b0;
        busy     <= 1'b0;
        state    <= S_IDLE;
      end
    end
  end

  assign bus.ack_o       = ack;
  assign bus.err_o       = err;
  assign bus.busy_o      = busy;
  assign bus.cur_freq_o  = cur_freq;
  assign bus.drp_daddr_o = daddr;
  assign bus.drp_di_o    = di;
  assign bus.drp_den_o   = den;
  assign bus.drp_dwe_o   = dwe;
  assign bus.mmcm_rst_o  = mmcm_rst;

endmodule

// File: tb/tb_dfs_drp_ctrl.sv
// Directed bench for dfs_drp_ctrl with a transaction-level outcome model,
// a DRP write scoreboard and an autonomous DRP/MMCM responder.
module tb_dfs_drp_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dfs_drp_ctrl_if #(.DATA_WIDTH(13)) bus ();
  dfs_drp_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Operating point table and divider arithmetic from the datasheet rules
  int unsigned ftab [6] = '{480, 440, 400, 360, 320, 280};
  int unsigned dtab [6] = '{16, 17, 19, 21, 24, 27};

  function automatic logic [31:0] enc(input int unsigned d);
    int unsigned hi, lo, r1, r2;
    hi = d / 2;
    lo = d - hi;
    if (d == 1) begin hi = 1; lo = 1; end
    r1 = hi * 64 + lo;
    r2 = (d % 2) * 128 + ((d == 1) ? 64 : 0);
    return {r1[15:0], r2[15:0]};
  endfunction

  function automatic int first(input int q[$]);
    return (q.size() > 0) ? q[0] : -1000;
  endfunction

  // Outcome model: 0 none, 1 reject, 2 same, 3 change, 4 watchdog abort
  bit            exp_err = 1'b0;
  int unsigned   exp_cur = 440;
  int            kind    = 0;
  int unsigned   tgt     = 0;
  logic [22:0]   wr_q [$];

  task automatic model_issue(input int unsigned code, input bit to);
    int idx = -1;
    logic [31:0] e;
    for (int i = 0; i < 6; i++) if (ftab[i] == code) idx = i;
    if (idx < 0)              kind = 1;
    else if (code == exp_cur) kind = 2;
    else begin
      kind = to ? 4 : 3;
      tgt  = code;
      e    = enc(dtab[idx]);
      wr_q.push_back({7'h08, e[31:16]});
      wr_q.push_back({7'h09, e[15:0]});
    end
  endtask

  task automatic model_reset();
    exp_err = 1'b0;
    exp_cur = 440;
    kind    = 0;
    wr_q.delete();
  endtask

  int ack_q [$], den_q [$], rise_q [$], fall_q [$];
  bit chk_en = 1'b0, prev_ack = 1'b0, prev_mr = 1'b0;

  // Per-cycle compare against the model and event capture
  always @(negedge clk) if (chk_en) begin
    if (bus.ack_o) begin
      ack_q.push_back(cyc);
      chk("ack_single", 32'(prev_ack), 32'd0);
      chk("ack_expected", 32'(kind != 0), 32'd1);
      case (kind)
        1: exp_err = 1'b1;
        3: exp_cur = tgt;
        4: begin exp_err = 1'b1; wr_q.delete(); end
        default: ;
      endcase
      kind = 0;
    end
    if (bus.drp_den_o) begin
      den_q.push_back(cyc);
      chk("den_dwe", 32'(bus.drp_dwe_o), 32'd1);
      chk("den_expected", 32'(wr_q.size() != 0), 32'd1);
      if (wr_q.size() != 0) chk("drp_write", 32'({bus.drp_daddr_o, bus.drp_di_o}), 32'(wr_q.pop_front()));
    end else begin
      chk("dwe_idle", 32'(bus.drp_dwe_o), 32'd0);
    end
    chk("err", 32'(bus.err_o), 32'(exp_err));
    chk("cur_freq", 32'(bus.cur_freq_o), exp_cur);
    if (bus.mmcm_rst_o && !prev_mr) rise_q.push_back(cyc);
    if (!bus.mmcm_rst_o && prev_mr) fall_q.push_back(cyc);
    prev_ack = bus.ack_o;
    prev_mr  = bus.mmcm_rst_o;
  end

  // Responder: drdy two cycles after each den, lock five cycles after release
  bit drdy_mode = 1'b1;
  int drdy_at = -10, rel_cyc = -100;
  bit mr_seen = 1'b0;
  always @(negedge clk) begin
    if (bus.drp_den_o && drdy_mode) drdy_at = cyc + 2;
    if (!bus.mmcm_rst_o && mr_seen) rel_cyc = cyc;
    mr_seen = bus.mmcm_rst_o;
  end
  initial begin
    bus.drp_drdy_i    = 1'b0;
    bus.mmcm_locked_i = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.drp_drdy_i    = drdy_mode && (cyc == drdy_at);
      bus.mmcm_locked_i = !bus.mmcm_rst_o && (cyc >= rel_cyc + 5);
    end
  end

  int c0;

  task automatic send(input int unsigned code, input bit to);
    @(posedge clk);
    #1;
    ack_q.delete(); den_q.delete(); rise_q.delete(); fall_q.delete();
    c0 = cyc;
    model_issue(code, to);
    bus.req_en_i   = 1'b1;
    bus.req_data_i = 13'(code);
    @(posedge clk);
    #1;
    bus.req_en_i = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    while (n < limit) begin
      @(negedge clk);
      #1;
      n++;
      if (ack_q.size() > 0 && !bus.busy_o) break;
    end
    chk("done_in_time", 32'(n < limit), 32'd1);
    repeat (3) @(negedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    bus.req_en_i   = 1'b0;
    bus.req_data_i = '0;
    chk("enc19", enc(19), 32'h024A_0080);
    chk("enc27", enc(27), 32'h034E_0080);
    chk("enc1",  enc(1),  32'h0041_00C0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_ack",   32'(bus.ack_o), 32'd0);
    chk("rst_err",   32'(bus.err_o), 32'd0);
    chk("rst_busy",  32'(bus.busy_o), 32'd0);
    chk("rst_cur",   32'(bus.cur_freq_o), 32'd440);
    chk("rst_drp",   32'({bus.drp_den_o, bus.drp_dwe_o, bus.drp_daddr_o, bus.drp_di_o}), 32'd0);
    chk("rst_mmcm",  32'(bus.mmcm_rst_o), 32'd0);
    chk_en = 1'b1;

    // Same frequency as the initial operating point
    send(440, 1'b0);
    wait_idle(20);
    chk("same_ack_cyc", 32'(first(ack_q) - c0), 32'd1);
    chk("same_no_den",  32'(den_q.size()), 32'd0);
    chk("same_no_rst",  32'(rise_q.size()), 32'd0);

    // Full reprogram to 400 (D=19)
    send(400, 1'b0);
    @(negedge clk);
    #1;
    chk("chg_busy", 32'(bus.busy_o), 32'd1);
    wait_idle(100);
    chk("chg_rst_rise", 32'(first(rise_q) - c0), 32'd1);
    chk("chg_den_cnt",  32'(den_q.size()), 32'd2);
    chk("chg_den0",     32'(first(den_q) - c0), 32'd2);
    if (den_q.size() == 2) chk("chg_den1", 32'(den_q[1] - c0), 32'd5);
    chk("chg_rst_fall", 32'(first(fall_q) - c0), 32'd8);
    chk("chg_ack_cyc",  32'(first(ack_q) - c0), 32'd14);
    chk("chg_ack_cnt",  32'(ack_q.size()), 32'd1);
    chk("chg_cur",      32'(bus.cur_freq_o), 32'd400);

    // Unmatched code
    send(123, 1'b0);
    wait_idle(20);
    chk("rej_ack_cyc", 32'(first(ack_q) - c0), 32'd1);
    chk("rej_err",     32'(bus.err_o), 32'd1);
    chk("rej_cur",     32'(bus.cur_freq_o), 32'd400);
    chk("rej_no_den",  32'(den_q.size()), 32'd0);

    // Request 280 (D=27) with a stray strobe during S_WAIT1
    send(280, 1'b0);
    while (cyc < c0 + 6) @(posedge clk);
    #1;
    bus.req_en_i   = 1'b1;
    bus.req_data_i = 13'd480;
    @(posedge clk);
    #1;
    bus.req_en_i = 1'b0;
    wait_idle(100);
    chk("ign_ack_cnt", 32'(ack_q.size()), 32'd1);
    chk("ign_den_cnt", 32'(den_q.size()), 32'd2);
    chk("ign_cur",     32'(bus.cur_freq_o), 32'd280);
    chk("ign_err",     32'(bus.err_o), 32'd1);

    // Reset during S_LOCK
    send(360, 1'b0);
    while (cyc < c0 + 10) @(posedge clk);
    #1;
    chk_en = 1'b0;
    rst    = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    prev_ack = 1'b0;
    prev_mr  = 1'b0;
    chk_en   = 1'b1;
    @(negedge clk);
    #1;
    chk("mid_ack",  32'(bus.ack_o), 32'd0);
    chk("mid_err",  32'(bus.err_o), 32'd0);
    chk("mid_busy", 32'(bus.busy_o), 32'd0);
    chk("mid_cur",  32'(bus.cur_freq_o), 32'd440);
    chk("mid_mmcm", 32'(bus.mmcm_rst_o), 32'd0);
    chk("mid_den",  32'(bus.drp_den_o), 32'd0);

    // Even divide after recovery (320, D=24)
    send(320, 1'b0);
    wait_idle(100);
    chk("even_cur",     32'(bus.cur_freq_o), 32'd320);
    chk("even_den_cnt", 32'(den_q.size()), 32'd2);
    chk("even_ack_cyc", 32'(first(ack_q) - c0), 32'd14);

`ifdef DFS_WATCHDOG_EN
    // drdy never arrives: watchdog aborts from S_WAIT0
    drdy_mode = 1'b0;
    send(480, 1'b1);
    wait_idle(1200);
    chk("wd_ack_cyc",  32'(first(ack_q) - c0), 32'd1027);
    chk("wd_err",      32'(bus.err_o), 32'd1);
    chk("wd_mmcm",     32'(bus.mmcm_rst_o), 32'd0);
    chk("wd_fall",     32'(first(fall_q) - c0), 32'd1027);
    chk("wd_cur",      32'(bus.cur_freq_o), 32'd320);
    chk("wd_den_cnt",  32'(den_q.size()), 32'd1);
    drdy_mode = 1'b1;
`endif

    chk("wr_q_empty", 32'(wr_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
